// File: rtl/d_mem_pkg.sv
// Shared definitions for the pipelined data memory: byte-lane helpers,
// the response record carried through the read pipeline and FIFO, and parameter limits.
package d_mem_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 3;
    localparam int RESP_DATA_MAX  = 128;

    // rdata is sized for the widest supported word; narrower builds leave the top bits zero
    typedef struct packed {
        logic [RESP_DATA_MAX-1:0] rdata;
        logic                     we;
        logic                     err;
    } resp_t;

    function automatic int nb_of(input int data_width);
        return data_width / 8;
    endfunction

    // Big-endian: lane k carries the byte at addr + (NB-1-k)
    function automatic int lane_byte_offset(input int lane, input int nb);
        return nb - 1 - lane;
    endfunction

endpackage

// File: rtl/d_mem_pipe_if.sv
// Request/response handshake bundle for d_mem_pipe; the MEM stage is the master,
// the memory is the slave.
interface d_mem_pipe_if
    import d_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    localparam int NB = nb_of(DATA_WIDTH);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NB-1:0]         req_strb;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_we;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_strb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_strb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );

endinterface

// File: rtl/d_mem_resp_fifo.sv
// Generic show-ahead FIFO: pop_data presents the head entry and reads as zero when empty.
// Pushes while full and pops while empty are ignored.
module d_mem_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/d_mem_pipe.sv
// Byte-addressable big-endian data memory with configurable read latency and a skid FIFO
// on the response side. Define DMEM_MISALIGN_ERR_EN to reject misaligned accesses with resp_err.
module d_mem_pipe
    import d_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    d_mem_pipe_if.slave bus
);
    localparam int NB        = nb_of(DATA_WIDTH);
    localparam int MEM_BYTES = 2 ** ADDR_WIDTH;
    localparam int CW        = $clog2(RESP_DEPTH + 1);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("d_mem_pipe: RD_LATENCY out of range");
    end
    if (RESP_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("d_mem_pipe: RESP_DEPTH must be at least RD_LATENCY+1");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > RESP_DATA_MAX) begin : g_bad_width
        $error("d_mem_pipe: unsupported DATA_WIDTH");
    end

    logic [7:0]            mem [MEM_BYTES];
    logic                  accept;
    logic                  resp_fire;
    logic                  misaligned;
    logic [CW-1:0]         inflight;
    resp_t                 next_resp;
    logic [RD_LATENCY-1:0] stage_valid;
    resp_t                 stage_data [RD_LATENCY];
    resp_t                 head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    logic                  unused_fifo_status;

    // Credit-based admission: the FIFO can always absorb everything already in flight
    assign bus.req_ready = rst_n && (inflight < CW'(RESP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign resp_fire     = bus.resp_valid && bus.resp_ready;

`ifdef DMEM_MISALIGN_ERR_EN
    assign misaligned = (bus.req_addr % ADDR_WIDTH'(NB)) != '0;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        next_resp     = '0;
        next_resp.we  = bus.req_we;
        next_resp.err = misaligned;
        if (!bus.req_we && !misaligned) begin
            for (int k = 0; k < NB; k++) begin
                next_resp.rdata[8*k +: 8] =
                    mem[bus.req_addr + ADDR_WIDTH'(lane_byte_offset(k, NB))];
            end
        end
    end

    // Storage is intentionally not reset; address arithmetic wraps at the top of memory
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !misaligned) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.req_strb[k]) begin
                    mem[bus.req_addr + ADDR_WIDTH'(lane_byte_offset(k, NB))] <=
                        bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            stage_valid[0] <= accept;
            stage_data[0]  <= next_resp;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({accept, resp_fire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    d_mem_resp_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stage_valid[RD_LATENCY-1]),
        .push_data (stage_data[RD_LATENCY-1]),
        .pop       (bus.resp_ready),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_rdata = head.rdata[DATA_WIDTH-1:0];
    assign bus.resp_we    = head.we;
    assign bus.resp_err   = head.err;

    assign unused_fifo_status = ^{head, fifo_full, fifo_count};

endmodule

// File: tb/tb_d_mem_pipe.sv
// Directed, table-driven bench for d_mem_pipe with hand-written sequences for latency,
// backpressure and mid-operation reset. Misalignment rows follow DMEM_MISALIGN_ERR_EN.
module tb_d_mem_pipe;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    d_mem_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    d_mem_pipe #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input string name, input logic we, input logic [AW-1:0] addr,
                                    input logic [DW-1:0] wdata, input logic [3:0] strb,
                                    input logic [DW-1:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name      = name;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.strb      = strb;
        v.exp_rdata = exp_rdata;
        v.exp_err   = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout expected=handshake", name);
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows the accept edge
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [3:0] strb, output bit accepted);
        bit ready_seen;
        accepted      = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        for (int c = 0; c < 50 && !accepted; c++) begin
            ready_seen = bus.req_ready;
            @(posedge clk);
            if (ready_seen) accepted = 1'b1;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (!accepted) fail_now("req_accept");
    endtask

    task automatic checkOutput(input string name, input logic exp_we, input logic [DW-1:0] exp_rdata,
                               input logic exp_err);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.resp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            fail_now({name, "_resp"});
        end else begin
            check({name, "_rdata"}, bus.resp_rdata, exp_rdata);
            check({name, "_we"}, DW'(bus.resp_we), DW'(exp_we));
            check({name, "_err"}, DW'(bus.resp_err), DW'(exp_err));
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit            ok;
        int            lat;
        int            idx;
        int            got;
        int            stale;
        bit            ready_seen;
        bit            rv;
        logic [DW-1:0] bp_exp [6];

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_strb   = '0;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", DW'(bus.req_ready), 0);
        check("rst_resp_valid", DW'(bus.resp_valid), 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_we", DW'(bus.resp_we), 0);
        check("rst_resp_err", DW'(bus.resp_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", DW'(bus.req_ready), 1);

        // First write with latency measurement in cycles from request presentation
        applyStimulus(1'b1, 12'h010, 32'hA1B2C3D4, 4'hF, ok);
        lat = 1;
        for (int c = 0; c < 20 && !bus.resp_valid; c++) begin
            @(negedge clk);
            lat++;
        end
        check("first_latency", DW'(lat), DW'(LAT + 1));
        checkOutput("first_wr", 1'b1, 32'h0, 1'b0);

        add_vec("read_full",   1'b0, 12'h010, 32'h0,        4'h0, 32'hA1B2C3D4, 1'b0);
        add_vec("clr_00c",     1'b1, 12'h00C, 32'h0,        4'hF, 32'h0,        1'b0);
        add_vec("clr_014",     1'b1, 12'h014, 32'h0,        4'hF, 32'h0,        1'b0);
`ifndef DMEM_MISALIGN_ERR_EN
        add_vec("byte_010",    1'b0, 12'h00D, 32'h0,        4'h0, 32'h000000A1, 1'b0);
        add_vec("byte_013",    1'b0, 12'h013, 32'h0,        4'h0, 32'hD4000000, 1'b0);
`endif
        add_vec("partial_wr",  1'b1, 12'h010, 32'h11223344, 4'h3, 32'h0,        1'b0);
        add_vec("partial_rd",  1'b0, 12'h010, 32'h0,        4'h0, 32'hA1B23344, 1'b0);
        add_vec("nostrb_wr",   1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
        add_vec("nostrb_rd",   1'b0, 12'h010, 32'h0,        4'h0, 32'hA1B23344, 1'b0);
        add_vec("other_wr",    1'b1, 12'h020, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        add_vec("other_rd",    1'b0, 12'h020, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        add_vec("lane_hi_wr",  1'b1, 12'h020, 32'h55000000, 4'h8, 32'h0,        1'b0);
        add_vec("lane_hi_rd",  1'b0, 12'h020, 32'h0,        4'h0, 32'h55ADBEEF, 1'b0);
`ifndef DMEM_MISALIGN_ERR_EN
        add_vec("wrap_clr_ffc", 1'b1, 12'hFFC, 32'h0,        4'hF, 32'h0,        1'b0);
        add_vec("wrap_clr_000", 1'b1, 12'h000, 32'h0,        4'hF, 32'h0,        1'b0);
        add_vec("wrap_wr",      1'b1, 12'hFFE, 32'h01020304, 4'hF, 32'h0,        1'b0);
        add_vec("wrap_rd_ffc",  1'b0, 12'hFFC, 32'h0,        4'h0, 32'h00000102, 1'b0);
        add_vec("wrap_rd_000",  1'b0, 12'h000, 32'h0,        4'h0, 32'h03040000, 1'b0);
        add_vec("wrap_rd_ffe",  1'b0, 12'hFFE, 32'h0,        4'h0, 32'h01020304, 1'b0);
`else
        add_vec("mis_wr",       1'b1, 12'h012, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        add_vec("mis_rd",       1'b0, 12'h011, 32'h0,        4'h0, 32'h0,        1'b1);
        add_vec("mis_unchanged", 1'b0, 12'h010, 32'h0,       4'h0, 32'hA1B23344, 1'b0);
        add_vec("aligned_ok",   1'b0, 12'h020, 32'h0,        4'h0, 32'h55ADBEEF, 1'b0);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, ok);
            if (ok) checkOutput(vecs[i].name, vecs[i].we, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: six back-to-back reads against a stalled response channel
        for (int i = 0; i < 6; i++) begin
            bp_exp[i] = 32'hC0DE0000 + DW'(i * 17);
            applyStimulus(1'b1, AW'(12'h100 + 4 * i), bp_exp[i], 4'hF, ok);
            if (ok) checkOutput("bp_fill", 1'b1, 32'h0, 1'b0);
        end
        bus.resp_ready = 1'b0;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            if (cyc == 12) begin
                check("bp_accepted", DW'(idx), DW'(DEPTH));
                check("bp_ready_low", DW'(bus.req_ready), 0);
                check("bp_resp_held", DW'(bus.resp_valid), 1);
                bus.resp_ready = 1'b1;
            end
            if (idx < 6) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b0;
                bus.req_addr  = AW'(12'h100 + 4 * idx);
                bus.req_strb  = 4'h0;
            end else begin
                bus.req_valid = 1'b0;
            end
            ready_seen = bus.req_valid && bus.req_ready;
            rv         = bus.resp_valid && bus.resp_ready;
            if (rv) check("bp_resp_order", bus.resp_rdata, bp_exp[got]);
            @(posedge clk);
            if (ready_seen) idx++;
            if (rv) got++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (got < 6) fail_now("bp_drain");
        check("bp_all_accepted", DW'(idx), 6);
        repeat (3) @(negedge clk);
        check("bp_no_duplicate", DW'(bus.resp_valid), 0);

        // Reset with three reads in flight
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 12'h010, 32'h0, 4'h0, ok);
        end
        check("inflight_before_rst", DW'(bus.resp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", DW'(bus.resp_valid), 0);
        check("midrst_req_ready", DW'(bus.req_ready), 0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.resp_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) stale++;
        end
        check("no_stale_resp", DW'(stale), 0);
        check("ready_after_midrst", DW'(bus.req_ready), 1);
        applyStimulus(1'b0, 12'h010, 32'h0, 4'h0, ok);
        if (ok) checkOutput("data_kept", 1'b0, 32'hA1B23344, 1'b0);
        applyStimulus(1'b0, 12'h020, 32'h0, 4'h0, ok);
        if (ok) checkOutput("data_kept2", 1'b0, 32'h55ADBEEF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
